// File: rtl/audio_dac_pkg.sv
// Shared constants and code-conversion helpers for the sigma-delta audio DAC.
package audio_dac_pkg;

  // Widest sample the helpers handle; callers truncate the result to BIT_WIDTH.
  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Two's complement to offset binary: flip the sign bit of a width-bit code.
  function automatic logic [MAX_WIDTH-1:0] to_offset_binary(input logic [MAX_WIDTH-1:0] s,
                                                            input int unsigned width);
    return s ^ (32'd1 << (width - 1));
  endfunction

  // Code that produces 50% density: 0 for signed input, mid-scale for offset binary.
  function automatic logic [MAX_WIDTH-1:0] silence_code(input logic signed_input,
                                                        input int unsigned width);
    return signed_input ? '0 : (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/sd_channel.sv
// One first-order sigma-delta modulator: accumulator plus registered carry bit.
module sd_channel
  import audio_dac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_mute,
  input  logic [BIT_WIDTH-1:0] i_code,
  output logic                 o_pwm
);

  localparam logic [BIT_WIDTH-1:0] MID_SCALE = BIT_WIDTH'(silence_code(1'b0, BIT_WIDTH));

  logic [BIT_WIDTH-1:0] r_acc;
  logic                 r_pwm;
  logic [BIT_WIDTH-1:0] w_u;
  logic [BIT_WIDTH:0]   w_sum;

  // Mute substitutes mid-scale; the carry out of the sum is the density bit.
  always_comb begin
    w_u   = i_mute ? MID_SCALE : i_code;
    w_sum = {1'b0, r_acc} + {1'b0, w_u};
  end

  // Accumulator and output bit advance only on modulator ticks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_pwm <= 1'b0;
    end else if (i_tick) begin
      r_acc <= w_sum[BIT_WIDTH-1:0];
      r_pwm <= w_sum[BIT_WIDTH];
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/audio_sd_dac.sv
// Multi-channel first-order sigma-delta DAC with a one-deep frame buffer,
// per-period frame loading, mute, modulator clock divider and underrun count.
module audio_sd_dac
  import audio_dac_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned BIT_WIDTH     = 16,
  parameter bit          SIGNED_INPUT  = 1'b1,
  parameter int unsigned SAMPLE_PERIOD = 256,
  parameter int unsigned OSR_DIV       = 1
) (
  input  logic                          clk_audio,
  input  logic                          rst_n,
  input  logic [CHANNELS*BIT_WIDTH-1:0] sample_word,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          sample_strobe,
  input  logic                          mute,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [15:0]                   underrun_count
);

  localparam int unsigned FRAME_W  = CHANNELS * BIT_WIDTH;
  localparam int unsigned PERIOD_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DIV_W    = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  localparam logic [PERIOD_W-1:0]  PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(OSR_DIV - 1);
  localparam logic [BIT_WIDTH-1:0] SILENCE     =
      BIT_WIDTH'(silence_code(SIGNED_INPUT, BIT_WIDTH));

  logic [PERIOD_W-1:0] r_period_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_strobe;
  logic [FRAME_W-1:0]  r_pending;
  logic                r_pending_full;
  logic                r_ready;
  logic [FRAME_W-1:0]  r_active;
  logic                r_mute;
  logic [15:0]         r_underrun_count;

  logic                w_load;
  logic                w_tick;
  logic                w_accept;
  logic                w_pending_full_next;
  logic [15:0]         w_underrun_next;

  assign w_load   = (r_period_cnt == PERIOD_LAST);
  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_accept = sample_valid && r_ready;

  // Period and divider counters share a reset so ticks stay frame-aligned.
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_div_cnt    <= '0;
      r_strobe     <= 1'b0;
    end else begin
      r_period_cnt <= w_load ? '0 : r_period_cnt + 1'b1;
      r_div_cnt    <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_strobe     <= w_load;
    end
  end

  // A load always leaves the buffer empty: it drains a full buffer, and an
  // accept on the load cycle bypasses straight into the active frame.
  always_comb begin
    w_pending_full_next = r_pending_full;
    if (w_load) begin
      w_pending_full_next = 1'b0;
    end else if (w_accept) begin
      w_pending_full_next = 1'b1;
    end
  end

  // Holding buffer, ready flag and active frame.
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      r_pending_full <= 1'b0;
      r_ready        <= 1'b0;
      r_pending      <= '0;
      r_active       <= {CHANNELS{SILENCE}};
    end else begin
      r_pending_full <= w_pending_full_next;
      r_ready        <= !w_pending_full_next;
      if (w_accept && !w_load) begin
        r_pending <= sample_word;
      end
      if (w_load) begin
        if (r_pending_full) begin
          r_active <= r_pending;
        end else if (w_accept) begin
          r_active <= sample_word;
        end
      end
    end
  end

  // Underrun when a load finds nothing to take; saturates at full scale.
  assign w_underrun_next =
      (w_load && !r_pending_full && !w_accept && (r_underrun_count != UNDERRUN_MAX)) ?
      r_underrun_count + 16'd1 : r_underrun_count;

  // Underrun counter and mute synchroniser.
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      r_underrun_count <= '0;
      r_mute           <= 1'b0;
    end else begin
      r_underrun_count <= w_underrun_next;
      r_mute           <= mute;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [BIT_WIDTH-1:0] w_sample;
    logic [BIT_WIDTH-1:0] w_code;

    assign w_sample = r_active[c*BIT_WIDTH +: BIT_WIDTH];
    assign w_code   = SIGNED_INPUT ?
                      BIT_WIDTH'(to_offset_binary(MAX_WIDTH'(w_sample), BIT_WIDTH)) : w_sample;

    sd_channel #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_ch (
      .i_clk  (clk_audio),
      .i_rst_n(rst_n),
      .i_tick (w_tick),
      .i_mute (r_mute),
      .i_code (w_code),
      .o_pwm  (pwm_out[c])
    );
  end

  assign sample_ready   = r_ready;
  assign sample_strobe  = r_strobe;
  assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Bench for audio_sd_dac: two 2x8-bit instances, A (signed, OSR_DIV=1) and
// B (offset binary, OSR_DIV=4), both with a 16-cycle sample period.
module tb_audio_sd_dac;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] word_a = '0;
  logic        valid_a = 1'b0;
  logic        mute_a = 1'b0;
  logic        ready_a, strobe_a;
  logic [1:0]  pwm_a;
  logic [15:0] underrun_a;

  logic [15:0] word_b = '0;
  logic        valid_b = 1'b0;
  logic        mute_b = 1'b0;
  logic        ready_b, strobe_b;
  logic [1:0]  pwm_b;
  logic [15:0] underrun_b;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: frames pushed when offered, loaded frames captured on strobe.
  logic [15:0] exp_q_a[$];
  logic [15:0] obs_q_a[$];
  logic [15:0] exp_active_a = '0;

  audio_sd_dac #(
    .CHANNELS(2), .BIT_WIDTH(8), .SIGNED_INPUT(1'b1), .SAMPLE_PERIOD(16), .OSR_DIV(1)
  ) dut_a (
    .clk_audio(clk), .rst_n(rst_n), .sample_word(word_a), .sample_valid(valid_a),
    .sample_ready(ready_a), .sample_strobe(strobe_a), .mute(mute_a), .pwm_out(pwm_a),
    .underrun_count(underrun_a)
  );

  audio_sd_dac #(
    .CHANNELS(2), .BIT_WIDTH(8), .SIGNED_INPUT(1'b0), .SAMPLE_PERIOD(16), .OSR_DIV(4)
  ) dut_b (
    .clk_audio(clk), .rst_n(rst_n), .sample_word(word_b), .sample_valid(valid_b),
    .sample_ready(ready_b), .sample_strobe(strobe_b), .mute(mute_b), .pwm_out(pwm_b),
    .underrun_count(underrun_b)
  );

  always @(negedge clk) begin
    if (rst_n && strobe_a) obs_q_a.push_back(dut_a.r_active);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    exp_q_a.delete();
    obs_q_a.delete();
    exp_active_a = '0;
    rst_n = 1'b1;
  endtask

  task automatic send_a(input logic [15:0] w);
    int n = 0;
    exp_q_a.push_back(w);
    word_a = w;
    valid_a = 1'b1;
    while (!ready_a && n < 64) begin @(negedge clk); n++; end
    if (!ready_a) begin
      n_checks++; n_errors++;
      $display("FAIL send_a: sample_ready stayed 0 for %0d cycles", n);
    end
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic wait_strobe_a();
    int n = 0;
    do begin @(negedge clk); n++; end while (!strobe_a && n < 64);
    if (!strobe_a) begin
      n_checks++; n_errors++;
      $display("FAIL strobe_a: no sample_strobe within 64 cycles");
    end
  endtask

  task automatic wait_strobe_b();
    int n = 0;
    do begin @(negedge clk); n++; end while (!strobe_b && n < 64);
    if (!strobe_b) begin
      n_checks++; n_errors++;
      $display("FAIL strobe_b: no sample_strobe within 64 cycles");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid_a = 1'b1;
    valid_b = 1'b1;
    word_a = 16'hFFFF;
    word_b = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_checks++; if (pwm_a !== 2'b00) begin n_errors++; $display("FAIL reset_pwm_a: got %b want 00", pwm_a); end
    n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
    n_checks++; if (underrun_a !== 16'd0) begin n_errors++; $display("FAIL reset_underrun_a: got %h want 0000", underrun_a); end
    n_checks++; if (strobe_a !== 1'b0) begin n_errors++; $display("FAIL reset_strobe_a: got %b want 0", strobe_a); end
    n_checks++; if (pwm_b !== 2'b00) begin n_errors++; $display("FAIL reset_pwm_b: got %b want 00", pwm_b); end
    n_checks++; if (ready_b !== 1'b0) begin n_errors++; $display("FAIL reset_ready_b: got %b want 0", ready_b); end
    valid_a = 1'b0;
    valid_b = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_a !== 1'b1) begin n_errors++; $display("FAIL release_ready_a: got %b want 1", ready_a); end
    n_checks++; if (ready_b !== 1'b1) begin n_errors++; $display("FAIL release_ready_b: got %b want 1", ready_b); end
  endtask

  task automatic test_underrun_density();
    int ones0 = 0;
    int ones1 = 0;
    logic [15:0] got;
    do_reset();
    send_a(16'h7F00);  // ch1 = 8'h7F, ch0 = 8'h00
    repeat (4) wait_strobe_a();
    n_checks++; if (underrun_a !== 16'd3) begin n_errors++; $display("FAIL underrun_3: got %0d want 3", underrun_a); end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones0 += int'(pwm_a[0]);
      ones1 += int'(pwm_a[1]);
    end
    n_checks++; if (ones0 != 128) begin n_errors++; $display("FAIL density_ch0: got %0d ones want 128", ones0); end
    n_checks++; if (ones1 != 255) begin n_errors++; $display("FAIL density_ch1: got %0d ones want 255", ones1); end
    force dut_a.w_underrun_next = 16'hFFFD;
    @(negedge clk);
    release dut_a.w_underrun_next;
    wait_strobe_a();
    n_checks++; if (underrun_a !== 16'hFFFE) begin n_errors++; $display("FAIL underrun_near_max: got %h want FFFE", underrun_a); end
    wait_strobe_a();
    wait_strobe_a();
    n_checks++; if (underrun_a !== 16'hFFFF) begin n_errors++; $display("FAIL underrun_saturate: got %h want FFFF", underrun_a); end
    #1;
    while (obs_q_a.size() > 0) begin
      got = obs_q_a.pop_front();
      if (exp_q_a.size() > 0) exp_active_a = exp_q_a.pop_front();
      n_checks++;
      if (got !== exp_active_a) begin n_errors++; $display("FAIL underrun_frame: loaded %h want %h", got, exp_active_a); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [15:0] got;
    do_reset();
    send_a(16'h1234);
    n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL bp_stall: ready got %b want 0", ready_a); end
    exp_q_a.push_back(16'hABCD);
    word_a = 16'hABCD;
    valid_a = 1'b1;
    while (!ready_a && n < 64) begin @(negedge clk); n++; end
    n_checks++; if (strobe_a !== 1'b1) begin n_errors++; $display("FAIL bp_release: strobe got %b want 1 when ready rose", strobe_a); end
    @(negedge clk);
    valid_a = 1'b0;
    wait_strobe_a();
    n_checks++; if (underrun_a !== 16'd0) begin n_errors++; $display("FAIL bp_underrun: got %0d want 0", underrun_a); end
    #1;
    while (obs_q_a.size() > 0) begin
      got = obs_q_a.pop_front();
      if (exp_q_a.size() > 0) exp_active_a = exp_q_a.pop_front();
      n_checks++;
      if (got !== exp_active_a) begin n_errors++; $display("FAIL bp_order: loaded %h want %h", got, exp_active_a); end
    end
    // Leave a frame pending, then reset: it must be discarded without an underrun.
    send_a(16'h5555);
    do_reset();
    n_checks++; if (underrun_a !== 16'd0) begin n_errors++; $display("FAIL midreset_underrun: got %0d want 0", underrun_a); end
    wait_strobe_a();
    n_checks++; if (underrun_a !== 16'd1) begin n_errors++; $display("FAIL midreset_first_load: got %0d want 1", underrun_a); end
    #1;
    while (obs_q_a.size() > 0) begin
      got = obs_q_a.pop_front();
      if (exp_q_a.size() > 0) exp_active_a = exp_q_a.pop_front();
      n_checks++;
      if (got !== exp_active_a) begin n_errors++; $display("FAIL midreset_frame: loaded %h want %h", got, exp_active_a); end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] got;
    do_reset();
    wait_strobe_a();
    #1;
    while (obs_q_a.size() > 0) begin
      got = obs_q_a.pop_front();
      if (exp_q_a.size() > 0) exp_active_a = exp_q_a.pop_front();
      n_checks++;
      if (got !== exp_active_a) begin n_errors++; $display("FAIL bypass_silence: loaded %h want %h", got, exp_active_a); end
    end
    repeat (15) @(negedge clk);  // last cycle before the next load edge
    exp_q_a.push_back(16'hC3A5);
    word_a = 16'hC3A5;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    n_checks++; if (strobe_a !== 1'b1) begin n_errors++; $display("FAIL bypass_strobe: got %b want 1", strobe_a); end
    n_checks++; if (underrun_a !== 16'd1) begin n_errors++; $display("FAIL bypass_underrun: got %0d want 1", underrun_a); end
    n_checks++; if (ready_a !== 1'b1) begin n_errors++; $display("FAIL bypass_ready: got %b want 1", ready_a); end
    #1;
    while (obs_q_a.size() > 0) begin
      got = obs_q_a.pop_front();
      if (exp_q_a.size() > 0) exp_active_a = exp_q_a.pop_front();
      n_checks++;
      if (got !== exp_active_a) begin n_errors++; $display("FAIL bypass_frame: loaded %h want %h", got, exp_active_a); end
    end
  endtask

  task automatic test_mute_divider();
    int n = 0;
    int ones0 = 0;
    int ones1 = 0;
    int viol = 0;
    logic [1:0] prev;
    mute_b = 1'b1;
    do_reset();
    word_b = 16'hFF00;  // ch1 full scale, ch0 zero (offset binary)
    valid_b = 1'b1;
    while (!ready_b && n < 64) begin @(negedge clk); n++; end
    @(negedge clk);
    valid_b = 1'b0;
    wait_strobe_b();
    prev = pwm_b;
    // Ticks land on every 4th edge counted from the load edge.
    for (int j = 1; j <= 1024; j++) begin
      @(negedge clk);
      if (j % 4 == 0) begin
        ones0 += int'(pwm_b[0]);
        ones1 += int'(pwm_b[1]);
      end else if (pwm_b !== prev) begin
        viol++;
      end
      prev = pwm_b;
    end
    n_checks++; if (ones0 != 128) begin n_errors++; $display("FAIL mute_ch0: got %0d ones want 128", ones0); end
    n_checks++; if (ones1 != 128) begin n_errors++; $display("FAIL mute_ch1: got %0d ones want 128", ones1); end
    mute_b = 1'b0;
    ones0 = 0;
    ones1 = 0;
    for (int j = 1025; j <= 2048; j++) begin
      @(negedge clk);
      if (j % 4 == 0) begin
        ones0 += int'(pwm_b[0]);
        ones1 += int'(pwm_b[1]);
      end else if (pwm_b !== prev) begin
        viol++;
      end
      prev = pwm_b;
    end
    n_checks++; if (ones0 != 0) begin n_errors++; $display("FAIL unmute_ch0: got %0d ones want 0", ones0); end
    n_checks++; if (ones1 != 255) begin n_errors++; $display("FAIL unmute_ch1: got %0d ones want 255", ones1); end
    n_checks++; if (viol != 0) begin n_errors++; $display("FAIL div_hold: %0d off-tick changes want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_underrun_density();
    test_back_to_back();
    test_bypass();
    test_mute_divider();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
